// File: rtl/audio_i2s_rx.sv
// rtl/audio_i2s_rx.sv - WM8978 I2S ADC receiver that packs each left/right pair into one 32-bit word
module audio_i2s_rx #(
  parameter int WL = 16
) (
  input  logic        aud_bclk,
  input  logic        rst,
  input  logic        aud_lrc,
  input  logic        aud_adcdat,
  output logic        aud_rx_done,
  output logic [31:0] aud_adc_data,
  output logic        aud_frame_err
);

  localparam logic [5:0]  WL_CNT = 6'(WL);
  localparam int unsigned PAD    = 16 - WL;

  logic        lrc_q, lrc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [15:0] shift_q, shift_d;
  logic [15:0] left_hold_q, left_hold_d;
  logic        synced_q, synced_d;
  logic        left_valid_q, left_valid_d;
  logic        rx_done_q, rx_done_d;
  logic        frame_err_q, frame_err_d;
  logic [31:0] data_q, data_d;

  logic        edge_det;
  logic        capture;
  logic        slot_done;
  logic [15:0] word_pad;

  always_comb begin
    lrc_d        = aud_lrc;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    left_hold_d  = left_hold_q;
    synced_d     = synced_q;
    left_valid_d = left_valid_q;
    rx_done_d    = 1'b0;
    frame_err_d  = 1'b0;
    data_d       = data_q;

    edge_det  = (aud_lrc != lrc_q);
    synced_d  = synced_q | edge_det;
    capture   = synced_q && !edge_det && (cnt_q >= 6'd1) && (cnt_q <= WL_CNT);
    slot_done = capture && (cnt_q == WL_CNT);

    if (capture) begin
      shift_d = {shift_q[14:0], aud_adcdat};
    end
    // Stale bits above the WL just captured fall off the top here.
    word_pad = shift_d << PAD;

    if (edge_det) begin
      cnt_d = 6'd1;
    end else if (cnt_q != 6'd63) begin
      cnt_d = cnt_q + 6'd1;
    end

    // At an edge cnt_q is one past the last index of the ending slot.
    if (edge_det && synced_q && (cnt_q <= WL_CNT)) begin
      frame_err_d  = 1'b1;
      left_valid_d = 1'b0;
    end

    if (slot_done) begin
      if (!aud_lrc) begin
        left_hold_d  = word_pad;
        left_valid_d = 1'b1;
      end else if (left_valid_q) begin
        data_d       = {left_hold_q, word_pad};
        rx_done_d    = 1'b1;
        left_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge aud_bclk) begin
    if (rst) begin
      lrc_q        <= 1'b0;
      cnt_q        <= 6'd0;
      shift_q      <= 16'd0;
      left_hold_q  <= 16'd0;
      synced_q     <= 1'b0;
      left_valid_q <= 1'b0;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      data_q       <= 32'd0;
    end else begin
      lrc_q        <= lrc_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      left_hold_q  <= left_hold_d;
      synced_q     <= synced_d;
      left_valid_q <= left_valid_d;
      rx_done_q    <= rx_done_d;
      frame_err_q  <= frame_err_d;
      data_q       <= data_d;
    end
  end

  assign aud_rx_done   = rx_done_q;
  assign aud_adc_data  = data_q;
  assign aud_frame_err = frame_err_q;

endmodule

// File: doc/audio_i2s_rx.md
Name: audio_i2s_rx

Overview:
- Upstream stage of the audio cache/UDP transmit path.
- Deserialises WM8978 I2S ADC data on the codec bit clock.
- Packs one left/right sample pair into a 32-bit word and raises a one-cycle strobe per stereo frame.
- aud_adc_data / aud_rx_done drive the write side of the audio async FIFO directly, in the aud_bclk domain.

Parameters:
- WL, 16: valid bits per channel captured MSB-first. Legal range 1..16.
- Each channel is left-justified in its 16-bit half; the low (16-WL) bits of each half are zero.

Ports:
- aud_bclk  input  1  WM8978 bit clock; the only clock; all logic on its rising edge
- rst  input  1  synchronous reset, active-high
- aud_lrc  input  1  I2S word clock: 0 = left slot, 1 = right slot
- aud_adcdat  input  1  I2S serial ADC data, MSB first, standard 1-bit delay after LRC change
- aud_rx_done  output  1  one-cycle strobe: aud_adc_data holds a new stereo pair
- aud_adc_data  output  32  {left[15:0], right[15:0]}
- aud_frame_err  output  1  one-cycle strobe: a slot ended before WL bits were captured

Behaviour:
- Reset (rst=1 at a rising edge) clears all state:
  - aud_rx_done=0, aud_adc_data=0, aud_frame_err=0
  - lrc_d=0, bit counter=0, shift register=0, synced=0, left_valid=0
  - Reset asserted mid-slot discards partial data; nothing captured so far is output.
- LRC edge detection:
  - lrc_d is aud_lrc registered each cycle.
  - Edge cycle: aud_lrc != lrc_d. This is slot bit index k=0.
  - Out of reset, the first detected edge sets synced=1. No capture and no error occur before synced=1.
- Bit counter (6 bits):
  - Set to 1 at an edge cycle.
  - Otherwise increments each cycle, saturating at 63.
  - At k=0, aud_adcdat carries the previous slot's LSB and is ignored.
  - k=1..WL: aud_adcdat is shifted into the channel shift register, MSB first.
  - k>WL: ignored, so slots longer than WL+1 bclks are fine.
  - Minimum legal slot length is WL+1 bclks.
- Slot completion is at the cycle with k==WL:
  - Left slot (aud_lrc=0): latch the completed word into the left holding register; set left_valid=1.
  - Right slot (aud_lrc=1) with left_valid=1, on the same edge:
    - aud_adc_data <= {left_hold, right_word}, each word padded with (16-WL) LSB zeros;
    - aud_rx_done <= 1 for exactly one cycle;
    - left_valid <= 0.
  - Right slot with left_valid=0 (e.g. sync acquired mid-left slot): the word is discarded, no strobe.
  - Latency: aud_rx_done is high during the cycle after the edge that samples the right-channel bit k=WL.
- Short slot: an edge cycle occurs while synced=1 and the ending slot has not reached k==WL.
  - aud_frame_err <= 1 for one cycle.
  - left_valid <= 0.
  - The partial word is discarded.
  - The new slot still starts normally (counter=1).
- aud_adc_data holds its value between strobes; it changes only on a strobe cycle or reset.
- aud_rx_done and aud_frame_err are never high in the same cycle.
  - The short-slot check applies only to slots that did not complete, so a completing slot cannot also flag an error.
- Maximum rate: one strobe per left+right frame. No back-pressure; the downstream FIFO must accept every strobe.

Test Plan:
1. Basic frame:
   - Stimulus: WL=16, 32-bclk slots, left=0xA5C3, right=0x1234, after reset plus one sync edge.
   - Required: single aud_rx_done; aud_adc_data=0xA5C31234; strobe one cycle after right bit k=16 is sampled; aud_frame_err stays 0.
2. Continuous capture:
   - Stimulus: 8 back-to-back frames with incrementing pairs.
   - Required: strobes exactly 64 bclks apart; every pair correct and in order; no missing or extra strobes.
3. Mid-frame startup:
   - Stimulus: release rst midway through a right slot, then mid-left.
   - Required: no strobe until a full left slot followed by a full right slot; first output equals that frame's data.
4. Short slot:
   - Stimulus: LRC toggles after 10 bclks of a left slot.
   - Required: one aud_frame_err pulse at that edge; no strobe for that frame; the next well-formed frame outputs correctly.
5. Minimum slot and reduced WL:
   - Stimulus 1: WL=16, 17-bclk slots. Required: correct capture, no error.
   - Stimulus 2: WL=12, left bits 0xABC, right bits 0x123. Required: aud_adc_data=0xABC01230.
6. Reset mid-capture:
   - Stimulus: rst pulsed for one cycle during the right slot of an in-flight frame.
   - Required: all outputs 0 the cycle after; no strobe for the interrupted frame; correct output after resync on a full frame.
